// File: rtl/ibex_pkg.sv
// Shared types and helpers for the load/store data port.
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'b00,
    LSU_WAIT_GNT    = 2'b01,
    LSU_WAIT_RVALID = 2'b10,
    LSU_ERR_RESP    = 2'b11
  } lsu_fsm_e;

  // An access needs two bus words when its bytes cross a word boundary.
  function automatic logic needs_split(lsu_type_e t, logic [1:0] off);
    case (t)
      LSU_WORD: return off != 2'd0;
      LSU_HALF: return off == 2'd3;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(lsu_type_e t);
    case (t)
      LSU_HALF: return 4'b0011;
      LSU_BYTE: return 4'b0001;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rotl_bytes(logic [31:0] d, logic [1:0] off);
    case (off)
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      2'd3:    return {d[7:0],  d[31:8]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Extracts and extends load data from the current bus word, merged with the
// held upper bytes of part 1 when the access was split.
module ibex_lsu_rdata_align
  import ibex_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [23:0] hold_i,
  input  logic        split_i,
  input  logic [1:0]  off_i,
  input  lsu_type_e   type_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [55:0] merged;
  logic [1:0]  shift;
  logic [31:0] win;

  always_comb begin
    merged = split_i ? {rdata_i, hold_i} : {24'd0, rdata_i};
    // hold_i starts at part-1 byte 1, so a split access is one byte lower.
    shift  = split_i ? off_i - 2'd1 : off_i;
    win    = merged[{1'b0, shift, 3'b000} +: 32];
    case (type_i)
      LSU_HALF: data_o = {{16{sign_i & win[15]}}, win[15:0]};
      LSU_BYTE: data_o = {{24{sign_i & win[7]}}, win[7:0]};
      default:  data_o = win;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_data_port.sv
// Load/store data port: one request at a time, misaligned accesses split into
// two word-aligned bus transactions.
//   state           | meaning
//   LSU_IDLE        | no request in flight; bus request follows lsu_req_i
//   LSU_WAIT_GNT    | bus request held until grant (part 1 or part 2)
//   LSU_WAIT_RVALID | waiting for the bus response of the granted part
//   LSU_ERR_RESP    | rejected misaligned access, error response this cycle
module ibex_lsu_data_port
  import ibex_pkg::*;
#(
  parameter bit MisalignedEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_req_done_o,
  output logic        lsu_busy_o,

  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,

  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o
);

  lsu_fsm_e    state_q;
  logic [1:0]  off_q;
  lsu_type_e   type_q;
  logic        sign_q;
  logic        we_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic        split_q;
  logic        part2_q;
  logic [23:0] hold_q;

  logic        idle;
  logic [1:0]  cur_off;
  lsu_type_e   cur_type;
  logic [29:0] cur_waddr;
  logic [31:0] cur_wdata;
  logic        cur_we;
  logic        cur_part2;
  logic        cur_split;
  logic        reject;
  logic        part1_of_split;
  logic [7:0]  be_wide;
  logic [31:0] rdata_aligned;

  logic        req;
  logic        done;
  logic        resp_valid;
  logic        resp_err;

  // In IDLE the bus sees the incoming request directly so a zero-wait grant
  // can land in the acceptance cycle.
  assign idle      = state_q == LSU_IDLE;
  assign cur_off   = idle ? lsu_addr_i[1:0]        : off_q;
  assign cur_type  = idle ? lsu_type_e'(lsu_type_i) : type_q;
  assign cur_waddr = idle ? lsu_addr_i[31:2]       : waddr_q;
  assign cur_wdata = idle ? lsu_wdata_i            : wdata_q;
  assign cur_we    = idle ? lsu_we_i               : we_q;
  assign cur_part2 = idle ? 1'b0                   : part2_q;
  assign cur_split = needs_split(cur_type, cur_off);

  assign reject         = idle & lsu_req_i & cur_split & ~MisalignedEn;
  assign part1_of_split = split_q & ~part2_q;
  assign be_wide        = {4'b0000, size_mask(cur_type)} << cur_off;

  always_comb begin
    req        = 1'b0;
    done       = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (reject) begin
          done = 1'b1;
        end else if (lsu_req_i) begin
          req  = 1'b1;
          done = data_gnt_i & ~cur_split;
        end
      end
      LSU_WAIT_GNT: begin
        req  = 1'b1;
        done = data_gnt_i & ~part1_of_split;
      end
      LSU_WAIT_RVALID: begin
        if (data_rvalid_i && !(part1_of_split && !data_err_i)) begin
          resp_valid = 1'b1;
          resp_err   = data_err_i;
          done       = data_err_i & part1_of_split;
        end
      end
      LSU_ERR_RESP: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_IDLE;
      off_q   <= 2'd0;
      type_q  <= LSU_WORD;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 30'd0;
      wdata_q <= 32'd0;
      split_q <= 1'b0;
      part2_q <= 1'b0;
      hold_q  <= 24'd0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            off_q   <= lsu_addr_i[1:0];
            type_q  <= lsu_type_e'(lsu_type_i);
            sign_q  <= lsu_sign_ext_i;
            we_q    <= lsu_we_i;
            waddr_q <= lsu_addr_i[31:2];
            wdata_q <= lsu_wdata_i;
            split_q <= cur_split;
            part2_q <= 1'b0;
            if (reject) begin
              state_q <= LSU_ERR_RESP;
            end else if (data_gnt_i) begin
              state_q <= LSU_WAIT_RVALID;
            end else begin
              state_q <= LSU_WAIT_GNT;
            end
          end
        end
        LSU_WAIT_GNT: begin
          if (data_gnt_i) begin
            state_q <= LSU_WAIT_RVALID;
          end
        end
        LSU_WAIT_RVALID: begin
          if (data_rvalid_i) begin
            if (part1_of_split && !data_err_i) begin
              hold_q  <= data_rdata_i[31:8];
              part2_q <= 1'b1;
              state_q <= LSU_WAIT_GNT;
            end else begin
              state_q <= LSU_IDLE;
            end
          end
        end
        LSU_ERR_RESP: state_q <= LSU_IDLE;
        default:      state_q <= LSU_IDLE;
      endcase
    end
  end

  ibex_lsu_rdata_align u_rdata_align (
    .rdata_i (data_rdata_i),
    .hold_i  (hold_q),
    .split_i (split_q),
    .off_i   (off_q),
    .type_i  (type_q),
    .sign_i  (sign_q),
    .data_o  (rdata_aligned)
  );

  // Bus payload is forced to zero whenever no request is presented.
  assign data_req_o   = req;
  assign data_addr_o  = req ? {cur_waddr + {29'd0, cur_part2}, 2'b00} : 32'd0;
  assign data_be_o    = req ? (cur_part2 ? be_wide[7:4] : be_wide[3:0]) : 4'd0;
  assign data_wdata_o = req ? rotl_bytes(cur_wdata, cur_off) : 32'd0;
  assign data_we_o    = req & cur_we;

  assign lsu_req_done_o   = done;
  assign lsu_busy_o       = ~idle;
  assign lsu_resp_valid_o = resp_valid;
  assign lsu_resp_err_o   = resp_err;
  assign rf_we_lsu_o      = resp_valid & ~we_q & ~resp_err;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? rdata_aligned : 32'd0;

endmodule
